fetch_prefetch: RTL and testbench
=================================

Name: fetch_prefetch

Overview:
Parametrised, decoupled instruction-fetch stage. It owns the fetch PC and issues one word-aligned request per cycle to a fixed-latency-1 instruction memory. Returned {pc, instr} pairs are buffered in a DEPTH-entry queue. The queue feeds decode through a valid/ready handshake, so decode stalls are absorbed without losing fetch bandwidth. A redirect from EX (taken branch/jump) flushes the queue and discards any response still in flight.

Parameters:
XLEN, 32, width of PC and instruction words
DEPTH, 4, prefetch queue entries; power of 2, >= 2
RESET_PC, 32'h0000_0000, fetch PC after reset; must be word-aligned

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
redirect_valid  in  1  EX redirect request (branch taken / jump)
redirect_pc  in  XLEN  redirect target; bits [1:0] ignored
imem_req  out  1  request valid this cycle
imem_addr  out  XLEN  request address, always word-aligned
imem_rvalid  in  1  response valid; asserted exactly 1 cycle after imem_req
imem_rdata  in  XLEN  response instruction word
out_valid  out  1  queue head valid towards decode
out_ready  in  1  decode accepts head this cycle
out_pc  out  XLEN  PC of head entry
out_instr  out  XLEN  instruction of head entry
occupancy  out  $clog2(DEPTH)+1  entries currently held, for debug and performance counters

Behaviour:
- Reset (async, any cycle):
  - fetch_pc = RESET_PC; queue count = 0; rd/wr pointers = 0; inflight = 0.
  - Outputs: imem_req=0, out_valid=0, occupancy=0. out_pc and out_instr are 0 while the queue is empty.
  - Release is synchronous to the next edge. The first request is issued in the first cycle after rst deasserts.
- State:
  - fetch_pc register.
  - inflight flag: 1 if imem_req was high in the previous cycle.
  - Circular queue of DEPTH {pc, instr} entries with rd_ptr, wr_ptr ($clog2(DEPTH) bits, natural wrap) and count.
- Issue:
  - imem_req = !redirect_valid && (count + inflight < DEPTH). Comparison uses $clog2(DEPTH)+2 bits, no overflow.
  - imem_addr = fetch_pc.
  - When imem_req is high, fetch_pc <= fetch_pc + 4, modulo 2^XLEN. Wrap from 0xFFFF_FFFC to 0 is legal.
- Response:
  - When imem_rvalid && !redirect_valid, write {pc_of_request, imem_rdata} at wr_ptr, then wr_ptr++.
  - pc_of_request is a register capturing imem_addr when the request is issued.
  - The credit rule guarantees a write never targets a full queue. A bench assertion flags imem_rvalid while count==DEPTH.
- Dequeue:
  - out_valid = (count != 0); head = entry[rd_ptr].
  - A pop occurs when out_valid && out_ready && !redirect_valid; rd_ptr++.
  - Push and pop in the same cycle leave count unchanged.
- Redirect (highest priority, single cycle):
  - count <= 0, rd_ptr <= wr_ptr, inflight <= 0.
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - imem_req = 0 in the redirect cycle, and any imem_rvalid arriving that cycle is discarded.
  - A pop attempted in the same cycle is suppressed (decode also flushes).
  - The first request to the target goes out the next cycle.
- Latency:
  - Request at cycle t, queue write at t+1, out_valid at t+2.
  - Redirect at cycle r gives target instruction at out_valid in cycle r+3.
  - Steady-state throughput is 1 instr/cycle with out_ready held high.
- out_pc/out_instr are stable while out_valid && !out_ready, unless a redirect occurs.

Decomposition:
- Package fetch_pkg holds:
  - XLEN default and ILEN;
  - INSTR_ALIGN_MASK = 32'hFFFF_FFFC;
  - the PC increment constant 4;
  - a typedef fetch_entry_t = {pc, instr}.
- Sub-module fetch_fifo: a generic synchronous circular FIFO with a flush input. It has parameters WIDTH and DEPTH, ports push/pop/flush/count, and async active-high rst.
- Top level keeps fetch_pc, the credit logic and the redirect logic.

Test Plan:
1. Reset release, out_ready=1, memory returns instr=addr^32'hA5A5_0000 → imem_addr 0,4,8,… on consecutive cycles; out_valid first high 2 cycles after the first req with out_pc=0; then one instr/cycle.
2. DEPTH=4, out_ready=0 → requests for 0,4,8,12 only, imem_req low from the 5th cycle, occupancy=4. Raise out_ready → heads 0,4,8,12 in order; the next request has addr 16.
3. Streaming, redirect_valid=1 with redirect_pc=32'h100 → that cycle imem_req=0 and the response is dropped. Next cycle out_valid=0, occupancy=0, imem_addr=0x100. out_pc=0x100 appears 3 cycles after the redirect.
4. Redirect with out_valid&&out_ready in the same cycle and redirect_pc=32'h103 → no pop is counted; the next fetch address is 0x100.
5. Assert rst asynchronously mid-stream, between edges → out_valid, imem_req and occupancy drop to 0 immediately. After release, fetch restarts at RESET_PC.
6. 20 instructions with random out_ready back-pressure → pointers wrap several times; the out_pc sequence is strictly 0,4,…,76 with no loss or duplication; occupancy never exceeds DEPTH.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and types for the instruction-fetch slice
package fetch_pkg;

    localparam int          XLEN             = 32;
    localparam int          ILEN             = 32;
    localparam logic [31:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] PC_INC           = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - generic synchronous circular FIFO with single-cycle flush
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   flush        : drops all entries (rd_ptr jumps to wr_ptr); overrides push/pop
//   push, din    : write din at wr_ptr; caller guarantees the FIFO is not full
//   pop          : advance rd_ptr; ignored while empty
//   dout         : head entry, zero while empty
//   count        : number of entries held
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;

    logic w_push;
    logic w_pop;

    assign w_push = push && !flush;
    assign w_pop  = pop && !flush && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            // Keep wr_ptr where it is so the storage position sequence is
            // continuous; emptiness comes from rd_ptr catching up.
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign dout  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign count = r_count;

endmodule

// File: rtl/fetch_prefetch.sv
// rtl/fetch_prefetch.sv - decoupled fetch stage: PC, credit-based issue, prefetch queue
//
// Ports:
//   clk, rst                   : clock, asynchronous active-high reset
//   redirect_valid/redirect_pc : EX redirect; flushes queue and in-flight response
//   imem_req/imem_addr         : one word-aligned request per cycle to latency-1 memory
//   imem_rvalid/imem_rdata     : memory response, one cycle after the request
//   out_valid/out_ready        : handshake of the queue head towards decode
//   out_pc/out_instr           : head entry, zero while the queue is empty
//   occupancy                  : entries currently buffered
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int               XLEN     = fetch_pkg::XLEN,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    redirect_valid,
    input  logic [XLEN-1:0]         redirect_pc,
    output logic                    imem_req,
    output logic [XLEN-1:0]         imem_addr,
    input  logic                    imem_rvalid,
    input  logic [XLEN-1:0]         imem_rdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_pc,
    output logic [XLEN-1:0]         out_instr,
    output logic [$clog2(DEPTH):0]  occupancy
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]   r_fetch_pc;
    logic [XLEN-1:0]   r_req_pc;
    logic              r_inflight;

    logic [CW-1:0]     w_count;
    logic [CW:0]       w_credit_used;
    logic              w_push;
    logic              w_pop;
    logic [2*XLEN-1:0] w_head;
    logic [XLEN-1:0]   w_pc_inc;
    logic [XLEN-1:0]   w_redirect_target;

    assign w_pc_inc          = XLEN'(PC_INC);
    assign w_redirect_target = redirect_pc & ~(w_pc_inc - XLEN'(1));

    // An outstanding request already owns a queue slot, so it is counted
    // against the free space before another request may go out.
    assign w_credit_used = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};

    // Gated by rst so the request drops as soon as reset is asserted,
    // not at the next edge.
    assign imem_req  = !rst && !redirect_valid && (w_credit_used < (CW+1)'(DEPTH));
    assign imem_addr = r_fetch_pc;

    assign out_valid = (w_count != '0);
    assign w_push    = imem_rvalid && !redirect_valid;
    assign w_pop     = out_valid && out_ready && !redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
        end else if (redirect_valid) begin
            r_fetch_pc <= w_redirect_target;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= imem_req;
            if (imem_req) begin
                r_req_pc   <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + w_pc_inc;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (w_push),
        .din   ({r_req_pc, imem_rdata}),
        .pop   (w_pop),
        .dout  (w_head),
        .count (w_count)
    );

    assign out_pc    = w_head[2*XLEN-1:XLEN];
    assign out_instr = w_head[XLEN-1:0];
    assign occupancy = w_count;

endmodule

// File: tb/tb_fetch_prefetch.sv
// tb/tb_fetch_prefetch.sv - directed self-checking bench for fetch_prefetch
module tb_fetch_prefetch;

    localparam int          DEPTH = 4;
    localparam logic [31:0] SALT  = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  occupancy;

    int n_checks;
    int n_pass;

    fetch_prefetch #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .occupancy      (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Latency-1 instruction memory: instr = addr ^ SALT
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
        end else begin
            imem_rvalid <= imem_req;
            imem_rdata  <= imem_addr ^ SALT;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // A response must never arrive into a full queue.
    always @(negedge clk) begin
        if (!rst && imem_rvalid) begin
            check("no_overflow", {31'd0, occupancy == 3'(DEPTH)}, 32'd0);
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] held_pc;
        logic        held;
        int          pops;

        n_checks       = 0;
        n_pass         = 0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_req",   {31'd0, imem_req},  32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_occ",   {29'd0, occupancy}, 32'd0);
        check("rst_pc",    out_pc,             32'd0);
        check("rst_instr", out_instr,          32'd0);

        // 1: streaming from reset
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            check("t1_req",  {31'd0, imem_req}, 32'd1);
            check("t1_addr", imem_addr, 32'(4 * c));
            if (c >= 2) begin
                check("t1_valid", {31'd0, out_valid}, 32'd1);
                check("t1_pc",    out_pc,    32'(4 * (c - 2)));
                check("t1_instr", out_instr, 32'(4 * (c - 2)) ^ SALT);
            end else begin
                check("t1_novalid", {31'd0, out_valid}, 32'd0);
            end
        end

        // 2: back-pressure fills the queue, then drains in order
        out_ready = 1'b0;
        reset_dut();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            if (c >= 6) out_ready = 1'b1;
            #1;
            if (c < 4) begin
                check("t2_req",  {31'd0, imem_req}, 32'd1);
                check("t2_addr", imem_addr, 32'(4 * c));
            end else if (c < 7) begin
                check("t2_noreq", {31'd0, imem_req}, 32'd0);
            end
            if (c == 5) check("t2_full", {29'd0, occupancy}, 32'd4);
            if (c >= 6) check("t2_head", out_pc, 32'(4 * (c - 6)));
            if (c == 7) begin
                check("t2_resume_req",  {31'd0, imem_req}, 32'd1);
                check("t2_resume_addr", imem_addr, 32'd16);
            end
        end

        // 3 + 4: redirect while streaming, then redirect during a pop
        out_ready = 1'b1;
        reset_dut();
        for (int c = 0; c < 14; c++) begin
            if (c > 0) @(negedge clk);
            redirect_valid = (c == 5) || (c == 9);
            redirect_pc    = (c == 5) ? 32'h100 : 32'h103;
            #1;
            case (c)
                5: begin
                    check("t3_redir_req",   {31'd0, imem_req},  32'd0);
                end
                6: begin
                    check("t3_flush_valid", {31'd0, out_valid}, 32'd0);
                    check("t3_flush_occ",   {29'd0, occupancy}, 32'd0);
                    check("t3_target_addr", imem_addr,          32'h100);
                    check("t3_target_req",  {31'd0, imem_req},  32'd1);
                end
                7: check("t3_gap_valid", {31'd0, out_valid}, 32'd0);
                8: begin
                    check("t3_tgt_valid", {31'd0, out_valid}, 32'd1);
                    check("t3_tgt_pc",    out_pc,    32'h100);
                    check("t3_tgt_instr", out_instr, 32'h100 ^ SALT);
                end
                9: begin
                    check("t4_pop_valid", {31'd0, out_valid}, 32'd1);
                    check("t4_redir_req", {31'd0, imem_req},  32'd0);
                end
                10: begin
                    check("t4_addr", imem_addr,          32'h100);
                    check("t4_occ",  {29'd0, occupancy}, 32'd0);
                end
                11: check("t4_gap_valid", {31'd0, out_valid}, 32'd0);
                12: check("t4_head0", out_pc, 32'h100);
                13: check("t4_head1", out_pc, 32'h104);
                default: ;
            endcase
        end
        redirect_valid = 1'b0;

        // 5: asynchronous reset between edges
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t5_valid", {31'd0, out_valid}, 32'd0);
        check("t5_req",   {31'd0, imem_req},  32'd0);
        check("t5_occ",   {29'd0, occupancy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_restart_req",  {31'd0, imem_req}, 32'd1);
        check("t5_restart_addr", imem_addr, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        check("t5_first_pc", out_pc, 32'd0);

        // 6: random back-pressure, 20 instructions in order
        reset_dut();
        exp_pc  = '0;
        pops    = 0;
        held    = 1'b0;
        held_pc = '0;
        for (int c = 0; c < 400 && pops < 20; c++) begin
            if (c > 0) @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            check("t6_occ_bound", {31'd0, occupancy <= 3'(DEPTH)}, 32'd1);
            if (held) check("t6_stable", out_pc, held_pc);
            held    = out_valid && !out_ready;
            held_pc = out_pc;
            if (out_valid && out_ready) begin
                check("t6_order", out_pc, exp_pc);
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
        end
        check("t6_count", 32'(pops), 32'd20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
